// File: rtl/hazard_scoreboard_unit_if.sv
// ID-stage hazard control bundle: decoded IF/ID operands and freeze/flush in, stall/bubble controls out.
// Perf counter outputs exist only when HAZ_PERF_CNT_EN is defined.
interface hazard_scoreboard_unit_if #(
  parameter int REG_AW   = 5,
  parameter int OP_W     = 6,
  parameter int MAX_PEND = 4
);
  logic [OP_W-1:0]                 Op_i;
  logic [REG_AW-1:0]               IFID_RsAddr_i;
  logic [REG_AW-1:0]               IFID_RtAddr_i;
  logic                            mem_busy_i;
  logic                            flush_i;
  logic                            PC_stall_o;
  logic                            IFID_stall_o;
  logic                            IDEX_bubble_o;
  logic [$clog2(MAX_PEND+1)-1:0]   pend_cnt_o;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]                     stall_cycles_o;
  logic [31:0]                     full_stalls_o;
`endif

  modport master (
    output Op_i, IFID_RsAddr_i, IFID_RtAddr_i, mem_busy_i, flush_i,
`ifdef HAZ_PERF_CNT_EN
    input  stall_cycles_o, full_stalls_o,
`endif
    input  PC_stall_o, IFID_stall_o, IDEX_bubble_o, pend_cnt_o
  );

  modport slave (
    input  Op_i, IFID_RsAddr_i, IFID_RtAddr_i, mem_busy_i, flush_i,
`ifdef HAZ_PERF_CNT_EN
    output stall_cycles_o, full_stalls_o,
`endif
    output PC_stall_o, IFID_stall_o, IDEX_bubble_o, pend_cnt_o
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Load-use scoreboard for the ID stage: outputs are combinational from state and inputs (0 cycle latency);
// mem_busy_i freezes all countdowns. Optional HAZ_PERF_CNT_EN adds saturating stall counters.
module hazard_scoreboard_unit #(
  parameter int REG_AW   = 5,
  parameter int OP_W     = 6,
  parameter int LOAD_LAT = 1,
  parameter int MAX_PEND = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  hazard_scoreboard_unit_if.slave   sb
);
  localparam int CW = $clog2(MAX_PEND+1);
  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  logic [MAX_PEND-1:0] valid_q, valid_d;
  logic [REG_AW-1:0]   dest_q [MAX_PEND];
  logic [REG_AW-1:0]   dest_d [MAX_PEND];
  logic [2:0]          cnt_q  [MAX_PEND];
  logic [2:0]          cnt_d  [MAX_PEND];

  logic                rs_used, rt_used, is_lw;
  logic                hazard, full, any_retire, load_stall, stall, issue, alloc_en;
  logic [MAX_PEND-1:0] retire, valid_post, alloc_oh;
  logic                found;
  logic [CW-1:0]       pend_cnt;

  always_comb begin
    rs_used = (sb.Op_i != OP_J) && (sb.IFID_RsAddr_i != '0);
    rt_used = ((sb.Op_i == OP_RTYPE) || (sb.Op_i == OP_BEQ) || (sb.Op_i == OP_SW))
              && (sb.IFID_RtAddr_i != '0);
    is_lw   = (sb.Op_i == OP_LW);
  end

  // A valid entry always has a nonzero count; it retires on the edge its count leaves 1.
  always_comb begin
    hazard = 1'b0;
    retire = '0;
    for (int i = 0; i < MAX_PEND; i++) begin
      if (valid_q[i] && (cnt_q[i] != 3'd0) &&
          ((rs_used && (dest_q[i] == sb.IFID_RsAddr_i)) ||
           (rt_used && (dest_q[i] == sb.IFID_RtAddr_i))))
        hazard = 1'b1;
      retire[i] = valid_q[i] && (cnt_q[i] == 3'd1) && !sb.mem_busy_i;
    end
  end

  always_comb begin
    full       = &valid_q;
    any_retire = |retire;
    load_stall = is_lw && full && !any_retire;
    stall      = (hazard || load_stall) && !sb.flush_i;
    issue      = !stall && !sb.mem_busy_i && !sb.flush_i;
    alloc_en   = issue && is_lw && (sb.IFID_RtAddr_i != '0);
    valid_post = valid_q & ~retire;
  end

  // Lowest free slot after this edge's retirements.
  always_comb begin
    found    = 1'b0;
    alloc_oh = '0;
    for (int i = 0; i < MAX_PEND; i++) begin
      if (!valid_post[i] && !found) begin
        alloc_oh[i] = alloc_en;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    dest_d  = dest_q;
    cnt_d   = cnt_q;
    if (!sb.mem_busy_i) begin
      for (int i = 0; i < MAX_PEND; i++) begin
        if (valid_q[i]) begin
          cnt_d[i] = cnt_q[i] - 3'd1;
          if (cnt_q[i] == 3'd1) valid_d[i] = 1'b0;
        end
        if (alloc_oh[i]) begin
          valid_d[i] = 1'b1;
          dest_d[i]  = sb.IFID_RtAddr_i;
          cnt_d[i]   = 3'(LOAD_LAT);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < MAX_PEND; i++) begin
        dest_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      dest_q  <= dest_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < MAX_PEND; i++) pend_cnt = pend_cnt + CW'(valid_q[i]);
  end

  // Gated by rst_i so a held mem_busy_i cannot leak a stall out during reset.
  assign sb.PC_stall_o    = !rst_i && (stall || sb.mem_busy_i);
  assign sb.IFID_stall_o  = !rst_i && (stall || sb.mem_busy_i);
  assign sb.IDEX_bubble_o = !rst_i && stall && !sb.mem_busy_i;
  assign sb.pend_cnt_o    = pend_cnt;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] full_stalls_q, full_stalls_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    full_stalls_d  = full_stalls_q;
    if (stall && !sb.mem_busy_i && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 32'd1;
    if (load_stall && !hazard && !sb.mem_busy_i && !sb.flush_i && (full_stalls_q != '1))
      full_stalls_d = full_stalls_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_q <= '0;
      full_stalls_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      full_stalls_q  <= full_stalls_d;
    end
  end

  assign sb.stall_cycles_o = stall_cycles_q;
  assign sb.full_stalls_o  = full_stalls_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench: three scoreboard configurations share one stimulus stream; each check targets one.
module tb_hazard_scoreboard_unit;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op  = OP_R;
  logic [4:0] rs  = '0;
  logic [4:0] rt  = '0;
  logic       busy  = 1'b0;
  logic       flush = 1'b0;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n;

  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(.REG_AW(5), .OP_W(6), .MAX_PEND(4)) if1 ();
  hazard_scoreboard_unit_if #(.REG_AW(5), .OP_W(6), .MAX_PEND(4)) if3 ();
  hazard_scoreboard_unit_if #(.REG_AW(5), .OP_W(6), .MAX_PEND(2)) if4 ();

  assign if1.Op_i = op;  assign if1.IFID_RsAddr_i = rs;  assign if1.IFID_RtAddr_i = rt;
  assign if1.mem_busy_i = busy;  assign if1.flush_i = flush;
  assign if3.Op_i = op;  assign if3.IFID_RsAddr_i = rs;  assign if3.IFID_RtAddr_i = rt;
  assign if3.mem_busy_i = busy;  assign if3.flush_i = flush;
  assign if4.Op_i = op;  assign if4.IFID_RsAddr_i = rs;  assign if4.IFID_RtAddr_i = rt;
  assign if4.mem_busy_i = busy;  assign if4.flush_i = flush;

  hazard_scoreboard_unit #(.REG_AW(5), .OP_W(6), .LOAD_LAT(1), .MAX_PEND(4))
    u_ll1 (.clk_i(clk), .rst_i(rst), .sb(if1));
  hazard_scoreboard_unit #(.REG_AW(5), .OP_W(6), .LOAD_LAT(3), .MAX_PEND(4))
    u_ll3 (.clk_i(clk), .rst_i(rst), .sb(if3));
  hazard_scoreboard_unit #(.REG_AW(5), .OP_W(6), .LOAD_LAT(4), .MAX_PEND(2))
    u_ll4 (.clk_i(clk), .rst_i(rst), .sb(if4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {PC_stall, IFID_stall, IDEX_bubble}
  function automatic logic [2:0] stv(input int sel);
    case (sel)
      1:       return {if1.PC_stall_o, if1.IFID_stall_o, if1.IDEX_bubble_o};
      3:       return {if3.PC_stall_o, if3.IFID_stall_o, if3.IDEX_bubble_o};
      default: return {if4.PC_stall_o, if4.IFID_stall_o, if4.IDEX_bubble_o};
    endcase
  endfunction

  function automatic logic [31:0] pend(input int sel);
    case (sel)
      1:       return 32'(if1.pend_cnt_o);
      3:       return 32'(if3.pend_cnt_o);
      default: return 32'(if4.pend_cnt_o);
    endcase
  endfunction

  task automatic drive(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t);
    op = o; rs = s; rt = t;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; busy = 1'b0; flush = 1'b0;
    drive(OP_R, 5'd0, 5'd0);
    step();
    rst = 1'b0;
  endtask

  // Counts bubble cycles with the current ID instruction held; returns mid-cycle of the issuing cycle.
  task automatic count_bub(input int sel, output int cnt);
    logic [2:0] s;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      #2;
      s = stv(sel);
      if (!s[0]) return;
      cnt++;
      step();
    end
    cnt = 99;
  endtask

  initial begin
    #1;
    chk("rst_stall_ll1", 32'(stv(1)), 32'd0);
    chk("rst_pend_ll4", pend(4), 32'd0);
    busy = 1'b1;
    #1;
    chk("rst_busy_masked", 32'(stv(3)), 32'd0);
    busy = 1'b0;
    step();
    rst = 1'b0;

    // LOAD_LAT=1: single bubble, then MEM/WB forwarding
    drive(OP_LW, 5'd0, 5'd8);
    #2 chk("t1_lw_issue", 32'(stv(1)), 32'd0);
    step();
    drive(OP_R, 5'd8, 5'd2);
    #2 chk("t1_dep_stall", 32'(stv(1)), 32'b111);
    chk("t1_pend1", pend(1), 32'd1);
    step();
    #2 chk("t1_dep_go", 32'(stv(1)), 32'd0);
    chk("t1_pend0", pend(1), 32'd0);
    step();

    // LOAD_LAT=3: back-to-back dependent beq, then with a nop in between
    do_reset();
    drive(OP_LW, 5'd0, 5'd5); step();
    drive(OP_BEQ, 5'd5, 5'd0);
    count_bub(3, n);
    chk("t2_beq_bubbles", 32'(n), 32'd3);
    step();
    do_reset();
    drive(OP_LW, 5'd0, 5'd5); step();
    drive(OP_R, 5'd0, 5'd0);  step();
    drive(OP_BEQ, 5'd5, 5'd0);
    count_bub(3, n);
    chk("t2_nop_bubbles", 32'(n), 32'd2);
    step();

    // $0 destination, jump, rs-only immediates
    do_reset();
    drive(OP_LW, 5'd0, 5'd0); step();
    chk("t3_lw0_pend", pend(1), 32'd0);
    drive(OP_R, 5'd0, 5'd0);
    #2 chk("t3_use0", 32'(stv(1)), 32'd0);
    step();
    drive(OP_LW, 5'd0, 5'd8); step();
    drive(OP_J, 5'd8, 5'd8);
    #2 chk("t3_jump", 32'(stv(3)), 32'd0);
    step();
    drive(OP_ADDI, 5'd8, 5'd9);
    #2 chk("t3_addi_rs", 32'(stv(3)), 32'b111);
    drive(OP_ADDI, 5'd3, 5'd8);
    #2 chk("t3_addi_rt", 32'(stv(3)), 32'd0);
    step();

    // MAX_PEND=2, LOAD_LAT=4: third load waits for a retirement and reuses its slot
    do_reset();
    drive(OP_LW, 5'd0, 5'd1); step();
    drive(OP_LW, 5'd0, 5'd2); step();
    chk("t4_full", pend(4), 32'd2);
    drive(OP_LW, 5'd0, 5'd3);
    count_bub(4, n);
    chk("t4_full_bubbles", 32'(n), 32'd2);
    step();
    chk("t4_pend_reuse", pend(4), 32'd2);
`ifdef HAZ_PERF_CNT_EN
    chk("t4_full_stalls", if4.full_stalls_o, 32'd2);
    chk("t4_stall_cycles", if4.stall_cycles_o, 32'd2);
`endif

    // mem_busy freeze in the middle of a load-use stall
    do_reset();
    drive(OP_LW, 5'd0, 5'd5); step();
    drive(OP_R, 5'd5, 5'd0);
    #2 chk("t5_stall", 32'(stv(3)), 32'b111);
    step();
    busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2 chk("t5_busy", 32'(stv(3)), 32'b110);
      step();
    end
    chk("t5_pend_frozen", pend(3), 32'd1);
    busy = 1'b0;
    count_bub(3, n);
    chk("t5_resume_bubbles", 32'(n), 32'd2);
    step();

    // flush priority, then asynchronous reset mid-stall
    do_reset();
    drive(OP_LW, 5'd0, 5'd5); step();
    flush = 1'b1;
    drive(OP_R, 5'd5, 5'd0);
    #2 chk("t6_flush_nostall", 32'(stv(3)), 32'd0);
    step();
    drive(OP_LW, 5'd0, 5'd7); step();
    flush = 1'b0;
    chk("t6_flush_noalloc", pend(3), 32'd1);
    drive(OP_R, 5'd5, 5'd0);
    #2 chk("t6_prerst_stall", 32'(stv(3)), 32'b111);
    #1 rst = 1'b1;
    #1 chk("t6_rst_stall", 32'(stv(3)), 32'd0);
    chk("t6_rst_pend", pend(3), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("t6_rst_perf", if3.stall_cycles_o, 32'd0);
`endif
    step();
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
